// File: rtl/mem_demux4.sv
`default_nettype none
// ============================================================================
// Module      : mem_demux4
// Description : Registered 1-to-4 data-memory request router. Routes a
//               single outstanding load/store to RAM/ROM/GPIO/timer by
//               address bits and returns the selected slave's response,
//               with decode-error and timeout reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_demux4 #(
    parameter int SEL_LSB = 28,
    parameter int TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [31:0]  req_addr,
    input  logic         req_we,
    input  logic [31:0]  req_wdata,
    input  logic [3:0]   req_wstrb,
    output logic         rsp_valid,
    output logic [31:0]  rsp_rdata,
    output logic         rsp_err,
    output logic [3:0]   s_valid,
    input  logic [3:0]   s_ready,
    output logic [31:0]  s_addr,
    output logic         s_we,
    output logic [31:0]  s_wdata,
    output logic [3:0]   s_wstrb,
    input  logic [3:0]   s_rvalid,
    input  logic [127:0] s_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    // Counter value seen in the last allowed ISSUE/WAIT cycle.
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

    state_t      r_state;
    logic [1:0]  r_sel;
    logic [7:0]  r_cnt;

    state_t      w_state;
    logic [1:0]  w_sel;
    logic [7:0]  w_cnt;
    logic [3:0]  w_s_valid;
    logic [31:0] w_s_addr;
    logic        w_s_we;
    logic [31:0] w_s_wdata;
    logic [3:0]  w_s_wstrb;
    logic        w_rsp_err;
    logic [31:0] w_rsp_rdata;
    logic        w_sel_ready;
    logic        w_sel_rvalid;
    logic [31:0] w_sel_rdata;
    logic [1:0]  w_req_sel;
    logic        w_dec_err;

    assign w_sel_ready  = s_ready[r_sel];
    assign w_sel_rvalid = s_rvalid[r_sel];
    assign w_sel_rdata  = s_rdata[{r_sel, 5'd0} +: 32];
    assign w_req_sel    = req_addr[SEL_LSB+1:SEL_LSB];
    assign w_dec_err    = (req_addr[31:SEL_LSB+2] != '0);

    // Next-state and next-output decode; only the selected slave is observed.
    always_comb begin
        w_state     = r_state;
        w_sel       = r_sel;
        w_cnt       = r_cnt;
        w_s_valid   = s_valid;
        w_s_addr    = s_addr;
        w_s_we      = s_we;
        w_s_wdata   = s_wdata;
        w_s_wstrb   = s_wstrb;
        w_rsp_err   = rsp_err;
        w_rsp_rdata = rsp_rdata;
        case (r_state)
            S_IDLE: begin
                if (req_valid) begin
                    w_s_addr  = req_addr;
                    w_s_we    = req_we;
                    w_s_wdata = req_wdata;
                    w_s_wstrb = req_wstrb;
                    w_sel     = w_req_sel;
                    if (w_dec_err) begin
                        w_state     = S_RESP;
                        w_rsp_err   = 1'b1;
                        w_rsp_rdata = 32'd0;
                    end else begin
                        w_state   = S_ISSUE;
                        w_cnt     = 8'd0;
                        w_s_valid = 4'b0001 << w_req_sel;
                    end
                end
            end
            S_ISSUE, S_WAIT: begin
                w_cnt = r_cnt + 8'd1;
                if (w_sel_rvalid && (r_state == S_WAIT || w_sel_ready)) begin
                    // Response captured; stores return zero data.
                    w_state     = S_RESP;
                    w_s_valid   = 4'b0000;
                    w_rsp_err   = 1'b0;
                    w_rsp_rdata = s_we ? 32'd0 : w_sel_rdata;
                end else if (r_cnt == c_tmo_last) begin
                    w_state     = S_RESP;
                    w_s_valid   = 4'b0000;
                    w_rsp_err   = 1'b1;
                    w_rsp_rdata = 32'd0;
                end else if (r_state == S_ISSUE && w_sel_ready) begin
                    w_state   = S_WAIT;
                    w_s_valid = 4'b0000;
                end
            end
            S_RESP: begin
                w_state = S_IDLE;
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset aborts any transaction in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= S_IDLE;
            r_sel     <= 2'd0;
            r_cnt     <= 8'd0;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            rsp_rdata <= 32'd0;
            s_valid   <= 4'b0000;
            s_addr    <= 32'd0;
            s_we      <= 1'b0;
            s_wdata   <= 32'd0;
            s_wstrb   <= 4'd0;
        end else begin
            r_state   <= w_state;
            r_sel     <= w_sel;
            r_cnt     <= w_cnt;
            req_ready <= (w_state == S_IDLE);
            rsp_valid <= (w_state == S_RESP);
            rsp_err   <= w_rsp_err;
            rsp_rdata <= w_rsp_rdata;
            s_valid   <= w_s_valid;
            s_addr    <= w_s_addr;
            s_we      <= w_s_we;
            s_wdata   <= w_s_wdata;
            s_wstrb   <= w_s_wstrb;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_demux4.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_demux4
// Description : Self-checking bench for mem_demux4: table of directed
//               transactions plus hand-written reset and late-response
//               sequences.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_demux4;

    localparam int c_tmo   = 255;
    localparam int c_never = 100000;
    localparam int c_bud   = 600;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic         req_we;
    logic [31:0]  req_wdata;
    logic [3:0]   req_wstrb;
    logic         rsp_valid;
    logic [31:0]  rsp_rdata;
    logic         rsp_err;
    logic [3:0]   s_valid;
    logic [3:0]   s_ready;
    logic [31:0]  s_addr;
    logic         s_we;
    logic [31:0]  s_wdata;
    logic [3:0]   s_wstrb;
    logic [3:0]   s_rvalid;
    logic [127:0] s_rdata;

    int checks = 0;
    int errors = 0;

    mem_demux4 #(.SEL_LSB(28), .TIMEOUT(c_tmo)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdata (req_wdata),
        .req_wstrb (req_wstrb),
        .rsp_valid (rsp_valid),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .s_addr    (s_addr),
        .s_we      (s_we),
        .s_wdata   (s_wdata),
        .s_wstrb   (s_wstrb),
        .s_rvalid  (s_rvalid),
        .s_rdata   (s_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        int          rdy;      // ISSUE cycles before s_ready (one-cycle pulse)
        int          rv;       // cycles from s_ready to s_rvalid
        logic [31:0] sdata;    // data the slave drives on its lane
        bit          xtalk;    // neighbouring slave spams ready/rvalid
        bit          dec;      // expected decode error
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;  // cycles from accept edge to rsp_valid
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic clear_slaves();
        s_ready  = 4'b0;
        s_rvalid = 4'b0;
        s_rdata  = '0;
    endtask

    // One transaction: request driven, slave behaviour scripted per cycle.
    task automatic run_vec(input vec_t v, input int idx);
        int          cyc;
        int          last_issue;
        int          sel;
        int          oth;
        bit          sval_ok;
        bit          bus_ok;
        logic [3:0]  exp_sv;
        string       tag;
        tag = $sformatf("v%0d", idx);
        sel = int'(v.addr[29:28]);
        oth = sel ^ 1;
        if (v.dec)                 last_issue = 0;
        else if (v.rdy >= c_never) last_issue = c_tmo;
        else                       last_issue = 1 + v.rdy;
        @(negedge clk);
        check({tag, "_ready_idle"}, {62'd0, req_ready, rsp_valid}, 64'd2);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_we    = v.we;
        req_wdata = v.wdata;
        req_wstrb = v.wstrb;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hFFFF_FFFF;
        req_wdata = 32'h0;
        cyc = 1;
        sval_ok = 1'b1;
        bus_ok  = 1'b1;
        while (cyc <= c_bud) begin
            exp_sv = (cyc <= last_issue) ? (4'b0001 << sel) : 4'b0000;
            if (s_valid !== exp_sv) sval_ok = 1'b0;
            if (s_addr !== v.addr || s_we !== v.we || s_wdata !== v.wdata || s_wstrb !== v.wstrb)
                bus_ok = 1'b0;
            if (rsp_valid) break;
            if (req_ready !== 1'b0) bus_ok = 1'b0;
            clear_slaves();
            if (v.xtalk) begin
                s_ready[oth]           = 1'b1;
                s_rvalid[oth]          = 1'b1;
                s_rdata[32*oth +: 32]  = 32'hDEAD_BEEF;
            end
            if (!v.dec) begin
                s_rdata[32*sel +: 32] = v.sdata;
                if (cyc == 1 + v.rdy)        s_ready[sel]  = 1'b1;
                if (cyc == 1 + v.rdy + v.rv) s_rvalid[sel] = 1'b1;
            end
            @(negedge clk);
            cyc++;
        end
        clear_slaves();
        check({tag, "_latency"}, 64'(cyc), 64'(v.exp_lat));
        check({tag, "_rdata"}, {32'd0, rsp_rdata}, {32'd0, v.exp_rdata});
        check({tag, "_err"}, {63'd0, rsp_err}, {63'd0, v.exp_err});
        check({tag, "_s_valid"}, {63'd0, sval_ok}, 64'd1);
        check({tag, "_bus_ready"}, {63'd0, bus_ok}, 64'd1);
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic we, input logic [31:0] wd,
                                input logic [3:0] ws, input int rdy, input int rv,
                                input logic [31:0] sd, input bit xt, input bit dec,
                                input logic [31:0] er, input logic ee, input int lat);
        vec_t v;
        v.addr = a; v.we = we; v.wdata = wd; v.wstrb = ws; v.rdy = rdy; v.rv = rv;
        v.sdata = sd; v.xtalk = xt; v.dec = dec; v.exp_rdata = er; v.exp_err = ee;
        v.exp_lat = lat;
        return v;
    endfunction

    initial begin
        bit quiet;
        vecs[0] = mk(32'h2000_0010, 1'b0, 32'h0,         4'hF, 0, 0, 32'hCAFE_BABE, 0, 0, 32'hCAFE_BABE, 1'b0, 2);
        vecs[1] = mk(32'h1000_0004, 1'b1, 32'h1234_5678, 4'b0011, 3, 2, 32'hFFFF_FFFF, 0, 0, 32'h0, 1'b0, 7);
        vecs[2] = mk(32'h4000_0000, 1'b0, 32'h0,         4'hF, c_never, 0, 32'h0, 0, 1, 32'h0, 1'b1, 1);
        vecs[3] = mk(32'h0000_0100, 1'b0, 32'h0,         4'hF, 1, 1, 32'hA5A5_A5A5, 1, 0, 32'hA5A5_A5A5, 1'b0, 4);
        vecs[4] = mk(32'h3000_0008, 1'b0, 32'h0,         4'hF, 0, 2, 32'h0BAD_F00D, 0, 0, 32'h0BAD_F00D, 1'b0, 4);
        vecs[5] = mk(32'h3000_0000, 1'b0, 32'h0,         4'hF, c_never, 0, 32'h5555_AAAA, 0, 0, 32'h0, 1'b1, c_tmo + 1);
        vecs[6] = mk(32'h8000_0004, 1'b1, 32'hFEED_0001, 4'b1000, c_never, 0, 32'h0, 0, 1, 32'h0, 1'b1, 1);
        vecs[7] = mk(32'h1000_0020, 1'b0, 32'h0,         4'b0101, 2, 0, 32'h1122_3344, 1, 0, 32'h1122_3344, 1'b0, 4);

        rst_n = 1'b0;
        req_valid = 1'b0; req_addr = '0; req_we = 1'b0; req_wdata = '0; req_wstrb = '0;
        clear_slaves();
        repeat (2) @(negedge clk);
        check("reset_ctrl", {60'd0, req_ready, rsp_valid, rsp_err, |s_valid}, 64'h8);
        check("reset_bus", {s_addr, s_wdata} | {59'd0, s_we, s_wstrb}, 64'd0);
        check("reset_rdata", {32'd0, rsp_rdata}, 64'd0);
        rst_n = 1'b1;

        // Back-to-back: each transaction is requested the cycle after rsp_valid.
        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        @(negedge clk);
        check("last_rsp_one_cycle", {62'd0, req_ready, rsp_valid}, 64'd2);

        // Timeout then a late s_rvalid[3]: must not create a response.
        run_vec(vecs[5], 8);
        @(negedge clk);
        s_ready[3] = 1'b1; s_rvalid[3] = 1'b1; s_rdata[127:96] = 32'h7777_7777;
        quiet = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            clear_slaves();
            if (rsp_valid !== 1'b0 || s_valid !== 4'b0 || req_ready !== 1'b1) quiet = 1'b0;
        end
        check("late_rvalid_ignored", {63'd0, quiet}, 64'd1);

        // Asynchronous reset in the middle of ISSUE.
        @(negedge clk);
        req_valid = 1'b1; req_addr = 32'h0000_0040; req_we = 1'b0; req_wdata = '0; req_wstrb = 4'hF;
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        check("pre_reset_issue", {60'd0, s_valid}, 64'h1);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_ctrl", {60'd0, req_ready, rsp_valid, |s_valid, rsp_err}, 64'h8);
        check("async_reset_addr", {32'd0, s_addr}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        for (int i = 0; i < c_tmo + 40; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b0 || s_valid !== 4'b0) quiet = 1'b0;
        end
        check("no_rsp_after_reset", {63'd0, quiet}, 64'd1);

        // Router still usable after the aborted transaction.
        run_vec(vecs[0], 9);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
